instr_encoder: RTL

- Inverse of the core's instruction decode: takes field-level instruction requests (opcode, func, registers, immediate) over a valid/ready handshake.
- Derives the WISC-SP13 format from the opcode, packs a 16-bit instruction word and range-checks the immediate.
- Writes the word into instruction memory at a sequential byte address through a held-request/ack write port.
- Used by the test infrastructure and boot loader to build programs in memory; stops after writing HALT.

---
 rtl/instr_encoder_pkg.sv | 29 ++
 rtl/instr_pack.sv | 36 +++
 rtl/instr_encoder.sv | 81 ++++++++
 3 files changed

// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg: WISC-SP13 opcodes, formats and error codes shared by encode/decode
package instr_encoder_pkg;
  localparam logic [4:0] OP_HALT  = 5'b00000;
  localparam logic [4:0] OP_NOP   = 5'b00001;
  localparam logic [4:0] OP_J     = 5'b00100;
  localparam logic [4:0] OP_JR    = 5'b00101;
  localparam logic [4:0] OP_JAL   = 5'b00110;
  localparam logic [4:0] OP_JALR  = 5'b00111;
  localparam logic [4:0] OP_ADDI  = 5'b01000;
  localparam logic [4:0] OP_XORI  = 5'b01010;
  localparam logic [4:0] OP_ANDNI = 5'b01011;
  localparam logic [4:0] OP_SLBI  = 5'b10010;
  localparam logic [4:0] OP_LBI   = 5'b11000;
  localparam logic [4:0] OP_SHIFT = 5'b11010;
  localparam logic [4:0] OP_ARITH = 5'b11011;
  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_RANGE = 2'd1;
  localparam logic [1:0] ERR_OVF   = 2'd2;
  typedef enum logic [2:0] {FMT_BARE, FMT_R, FMT_I1, FMT_I2, FMT_J} fmt_t;
  function automatic fmt_t opcode_fmt(input logic [4:0] op);
    return op >= 5'b11001 ? FMT_R :
      op inside {[OP_ADDI:OP_ANDNI], 5'b10000, 5'b10001, [5'b10011:5'b10111]} ? FMT_I1 :
      op inside {OP_JR, OP_JALR, [5'b01100:5'b01111], OP_SLBI, OP_LBI} ? FMT_I2 :
      op inside {OP_J, OP_JAL} ? FMT_J : FMT_BARE;
  endfunction
  function automatic logic opcode_zeroext(input logic [4:0] op);
    return op inside {OP_XORI, OP_ANDNI, [5'b10100:5'b10111], OP_SLBI};
  endfunction
endpackage

// File: rtl/instr_pack.sv
// instr_pack: packs instruction fields into a 16-bit word and flags out-of-range immediates
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [4:0]  opcode,
  input  logic [1:0]  func,
  input  logic [2:0]  rs,
  input  logic [2:0]  rt,
  input  logic [2:0]  rd,
  input  logic [10:0] imm,
  output logic [15:0] word,
  output logic        range_err
);
  fmt_t fmt;
  logic zx;
  assign fmt = opcode_fmt(opcode);
  assign zx  = opcode_zeroext(opcode);
  // signed ranges fit when all discarded upper bits equal the kept sign bit
  always_comb begin
    word = {opcode, 11'd0};
    range_err = 1'b0;
    case (fmt)
      FMT_R: word = {opcode, rs, rt, rd, opcode inside {OP_SHIFT, OP_ARITH} ? func : 2'b00};
      FMT_I1: begin
        word = {opcode, rs, rd, imm[4:0]};
        range_err = zx ? |imm[10:5] : !(&imm[10:4] || ~|imm[10:4]);
      end
      FMT_I2: begin
        word = {opcode, rs, imm[7:0]};
        range_err = zx ? |imm[10:8] : !(&imm[10:7] || ~|imm[10:7]);
      end
      FMT_J: word = {opcode, imm};
      default: ;
    endcase
  end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: accepts field-level instruction requests and writes encoded words to
// instruction memory at sequential addresses until HALT, overflow or a range error
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_opcode,
  input  logic [1:0]        in_func,
  input  logic [2:0]        in_rs,
  input  logic [2:0]        in_rt,
  input  logic [2:0]        in_rd,
  input  logic [10:0]       in_imm,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_data,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W-1:0] count
);
  typedef enum logic [2:0] {IDLE, ACCEPT, WRITE, DONE, ERROR} state_t;
  state_t state, state_n;
  logic [15:0] word;
  logic range_err, idle_like, accept, acked;
  instr_pack u_pack (
    .opcode(in_opcode), .func(in_func), .rs(in_rs), .rt(in_rt), .rd(in_rd),
    .imm(in_imm), .word(word), .range_err(range_err)
  );
  assign idle_like = state inside {IDLE, DONE, ERROR};
  assign accept    = state == ACCEPT && in_valid;
  assign acked     = state == WRITE && mem_ack;
  assign in_ready  = state == ACCEPT;
  assign busy      = state inside {ACCEPT, WRITE};
  assign mem_wr    = state == WRITE;
  assign done      = state == DONE;
  assign err       = state == ERROR;
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE, ERROR: state_n = start ? ACCEPT : state;
      ACCEPT: state_n = !in_valid ? ACCEPT : range_err ? ERROR : WRITE;
      WRITE: state_n = !mem_ack ? WRITE :
        mem_data[15:11] == OP_HALT ? DONE :
        count + 1'b1 == ADDR_W'(DEPTH_WORDS) ? ERROR : ACCEPT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      mem_addr <= '0;
      mem_data <= '0;
      count    <= '0;
      err_code <= ERR_NONE;
    end else begin
      state <= state_n;
      if (start && idle_like) begin
        mem_addr <= base_addr & ~ADDR_W'(1);
        count    <= '0;
        err_code <= ERR_NONE;
      end
      if (accept) mem_data <= word;
      if (accept && range_err) err_code <= ERR_RANGE;
      if (acked) begin
        count    <= count + 1'b1;
        mem_addr <= mem_addr + ADDR_W'(2);
      end
      if (acked && state_n == ERROR) err_code <= ERR_OVF;
    end
  end
endmodule
